// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 host-side blocks: the host transmitter
//   state encoding, frame geometry, default timing constants (24 MHz clk)
//   and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2TxState_t;

    // Device clock falls in one host-to-device frame: 8 data, parity,
    // stop and the ACK fall.
    localparam int PS2_NUM_TX_FALLS   = 11;
    // Bits held in the shift register: 8 data bits plus parity.
    localparam int PS2_NUM_SHIFT_BITS = 9;

    localparam int PS2_INHIBIT_CYCLES = 2880;    // 120 us at 24 MHz
    localparam int PS2_TIMEOUT_CYCLES = 360000;  // 15 ms at 24 MHz
    localparam int PS2_FILTER_LEN     = 4;
    localparam int PS2_MAX_RETRIES    = 2;

    // Parity bit that makes the count of ones over data+parity odd.
    function automatic logic oddParity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
//   Conditions one asynchronous PS/2 line: 2-flop synchronizer followed by
//   a run-length filter that only accepts a new level after FILTER_LEN
//   consecutive equal synchronized samples. Emits a 1-cycle pulse when the
//   filtered level falls. Input-to-fall latency is 2+FILTER_LEN cycles.
//   Shared by the host transmitter and the keyboard receiver.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset (level presets to 1)
//   lineIn  in   raw line level (asynchronous)
//   level   out  filtered line level
//   fall    out  1-cycle pulse on a filtered 1->0 transition
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic lineIn,
    output logic level,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] runCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            level  <= 1'b1;
            runCnt <= '0;
            fall   <= 1'b0;
        end else begin
            sync1 <= lineIn;
            sync2 <= sync1;
            fall  <= 1'b0;
            // runCnt counts how many samples in a row have disagreed with
            // the accepted level; the FILTER_LEN-th one flips the level.
            if (sync2 != level) begin
                if (runCnt == CNT_W'(FILTER_LEN - 1)) begin
                    level  <= sync2;
                    runCnt <= '0;
                    fall   <= level;  // old level 1 means this is a fall
                end else begin
                    runCnt <= runCnt + CNT_W'(1);
                end
            end else begin
                runCnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
//   (inhibit, request-to-send, 8 data + odd parity + stop, ACK), driving
//   both lines open-drain through drive-low enables, and reports the
//   outcome with txDone / txError.
//
//   Handshake: txReady is high only in IDLE; a byte is accepted on the
//   cycle txValid && txReady. txValid while busy is ignored (no queue).
//
//   Optional build macro PS2_TX_RETRY_EN: on nack or timeout the same byte
//   is re-sent from INHIBIT, up to two retries; txError only after the
//   third failure.
//
// Ports:
//   clk              in   system clock (24 MHz)
//   rst              in   synchronous active-high reset
//   txData[7:0]      in   command byte
//   txValid          in   send request
//   txReady          out  high in IDLE
//   KBD_CLK          in   PS/2 clock line level (async)
//   KBD_DATA         in   PS/2 data line level (async)
//   kbdClkDriveLow   out  1 = pull KBD_CLK low
//   kbdDataDriveLow  out  1 = pull KBD_DATA low
//   rxInhibit        out  high while the transmitter owns the bus
//   txDone           out  1-cycle pulse, byte acknowledged
//   txError          out  1-cycle pulse, no ACK or timeout
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    input  logic       KBD_CLK,
    input  logic       KBD_DATA,
    output logic       kbdClkDriveLow,
    output logic       kbdDataDriveLow,
    output logic       rxInhibit,
    output logic       txDone,
    output logic       txError
);

    localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDLE_W = $clog2(FILTER_LEN + 1);
    // Fall index (0-based count of falls already seen) that releases data.
    localparam logic [3:0] STOP_FALL = 4'(PS2_NUM_SHIFT_BITS);

    // ---------------- line conditioning ----------------
    logic clkLevel;
    logic fallCk;
    logic dataLevel;
    logic unusedDataFall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uClkFilter (
        .clk    (clk),
        .rst    (rst),
        .lineIn (KBD_CLK),
        .level  (clkLevel),
        .fall   (fallCk)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uDataFilter (
        .clk    (clk),
        .rst    (rst),
        .lineIn (KBD_DATA),
        .level  (dataLevel),
        .fall   (unusedDataFall)
    );

    // ---------------- state ----------------
    ps2TxState_t         state,   stateNext;
    logic [8:0]          shReg,   shNext;
    logic [3:0]          bitCnt,  bitCntNext;
    logic [INH_W-1:0]    inhCnt,  inhCntNext;
    logic [TO_W-1:0]     toCnt,   toCntNext;
    logic [IDLE_W-1:0]   idleCnt, idleCntNext;
    logic                acked,   ackedNext;
    logic                dataLow, dataLowNext;
    logic                doneR,   doneNext;
    logic                errorR,  errorNext;
    logic                failNow;
    logic                timeoutHit;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]          retryCnt, retryCntNext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shReg    <= '0;
            bitCnt   <= '0;
            inhCnt   <= '0;
            toCnt    <= '0;
            idleCnt  <= '0;
            acked    <= 1'b0;
            dataLow  <= 1'b0;
            doneR    <= 1'b0;
            errorR   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retryCnt <= '0;
`endif
        end else begin
            state    <= stateNext;
            shReg    <= shNext;
            bitCnt   <= bitCntNext;
            inhCnt   <= inhCntNext;
            toCnt    <= toCntNext;
            idleCnt  <= idleCntNext;
            acked    <= ackedNext;
            dataLow  <= dataLowNext;
            doneR    <= doneNext;
            errorR   <= errorNext;
`ifdef PS2_TX_RETRY_EN
            retryCnt <= retryCntNext;
`endif
        end
    end

    assign timeoutHit = (toCnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        stateNext   = state;
        shNext      = shReg;
        bitCntNext  = bitCnt;
        inhCntNext  = inhCnt;
        toCntNext   = toCnt;
        idleCntNext = idleCnt;
        ackedNext   = acked;
        dataLowNext = dataLow;
        doneNext    = 1'b0;
        errorNext   = 1'b0;
        failNow     = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retryCntNext = retryCnt;
`endif

        case (state)
            IDLE: begin
                if (txValid) begin
                    shNext      = {oddParity(txData), txData};
                    inhCntNext  = '0;
                    dataLowNext = 1'b0;
                    ackedNext   = 1'b0;
                    stateNext   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retryCntNext = '0;
`endif
                end
            end

            // The clock is held low for INHIBIT_CYCLES in total; the last of
            // those cycles is RTS, where data is also pulled low.
            INHIBIT: begin
                if (inhCnt == INH_W'(INHIBIT_CYCLES - 2)) begin
                    stateNext   = RTS;
                    dataLowNext = 1'b1;
                end else begin
                    inhCntNext = inhCnt + INH_W'(1);
                end
            end

            // Data stays low (start bit) while the clock is released.
            RTS: begin
                stateNext  = SEND;
                bitCntNext = '0;
                toCntNext  = '0;
            end

            SEND: begin
                if (timeoutHit) begin
                    failNow = 1'b1;
                end else begin
                    toCntNext = toCnt + TO_W'(1);
                    if (fallCk) begin
                        bitCntNext = bitCnt + 4'd1;
                        if (bitCnt == STOP_FALL) begin
                            dataLowNext = 1'b0;  // stop bit
                            stateNext   = ACK;
                        end else begin
                            dataLowNext = ~shReg[bitCnt];
                        end
                    end
                end
            end

            ACK: begin
                if (timeoutHit) begin
                    failNow = 1'b1;
                end else begin
                    toCntNext = toCnt + TO_W'(1);
                    if (fallCk) begin
                        ackedNext   = ~dataLevel;
                        idleCntNext = '0;
                        stateNext   = WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                if (timeoutHit) begin
                    failNow = 1'b1;
                end else begin
                    toCntNext = toCnt + TO_W'(1);
                    if (clkLevel && dataLevel) begin
                        if (idleCnt == IDLE_W'(FILTER_LEN - 1)) begin
                            if (acked) begin
                                doneNext  = 1'b1;
                                stateNext = IDLE;
                            end else begin
                                failNow = 1'b1;
                            end
                        end else begin
                            idleCntNext = idleCnt + IDLE_W'(1);
                        end
                    end else begin
                        idleCntNext = '0;
                    end
                end
            end

            default: stateNext = IDLE;
        endcase

        // Nack or timeout: release the bus, then either retry or report.
        if (failNow) begin
            dataLowNext = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retryCnt < 2'(PS2_MAX_RETRIES)) begin
                retryCntNext = retryCnt + 2'd1;
                inhCntNext   = '0;
                stateNext    = INHIBIT;
            end else begin
                errorNext = 1'b1;
                stateNext = IDLE;
            end
`else
            errorNext = 1'b1;
            stateNext = IDLE;
`endif
        end
    end

    // ---------------- outputs ----------------
    // Done/error are registered so they coincide with the first IDLE cycle,
    // the same cycle txReady rises and rxInhibit drops.
    assign txReady         = (state == IDLE);
    assign rxInhibit       = (state != IDLE);
    assign kbdClkDriveLow  = (state == INHIBIT) || (state == RTS);
    assign kbdDataDriveLow = dataLow;
    assign txDone          = doneR;
    assign txError         = errorR;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH = 2880;
    localparam int TMO = 6000;
    localparam int FLT = 4;
    localparam int HP  = 20;   // device clock half period in clk cycles
    localparam int NV  = 7;
`ifdef PS2_TX_RETRY_EN
    localparam int MAX_ATT = 3;
`else
    localparam int MAX_ATT = 1;
`endif

    // ---------------- clock / reset / bus ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] txData = 8'h00;
    logic       txValid = 1'b0;
    logic       txReady;
    logic       kbdClk;
    logic       kbdData;
    logic       kbdClkDriveLow;
    logic       kbdDataDriveLow;
    logic       rxInhibit;
    logic       txDone;
    logic       txError;
    logic       devClkLow = 1'b0;
    logic       devDataLow = 1'b0;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and device pull-downs.
    assign kbdClk  = ~(kbdClkDriveLow | devClkLow);
    assign kbdData = ~(kbdDataDriveLow | devDataLow);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .txData          (txData),
        .txValid         (txValid),
        .txReady         (txReady),
        .KBD_CLK         (kbdClk),
        .KBD_DATA        (kbdData),
        .kbdClkDriveLow  (kbdClkDriveLow),
        .kbdDataDriveLow (kbdDataDriveLow),
        .rxInhibit       (rxInhibit),
        .txDone          (txDone),
        .txError         (txError)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- bus monitor (negedge) ----------------
    int   cyc = 0;
    int   doneCnt = 0;
    int   errCnt = 0;
    int   bothCnt = 0;
    int   inhStarts = 0;
    int   lowStart = 0;
    int   lowLen = 0;
    int   relCyc = 0;
    int   errCyc = 0;
    int   dataLowInInh = 0;
    logic dataLowAtRel = 1'b0;
    logic inhAtRel = 1'b0;
    logic doneReady = 1'b0;
    logic doneInh = 1'b1;
    logic errReady = 1'b0;
    logic prevClkDrv = 1'b0;
    logic prevDataDrv = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (kbdClkDriveLow && !prevClkDrv) begin
            inhStarts++;
            lowStart = cyc;
            dataLowInInh = 0;
        end
        if (kbdClkDriveLow && kbdDataDriveLow) dataLowInInh++;
        if (!kbdClkDriveLow && prevClkDrv) begin
            lowLen = cyc - lowStart;
            relCyc = cyc;
            dataLowAtRel = prevDataDrv;
            inhAtRel = rxInhibit;
        end
        if (txDone) begin
            doneCnt++;
            doneReady = txReady;
            doneInh = rxInhibit;
        end
        if (txError) begin
            errCnt++;
            errCyc = cyc;
            errReady = txReady;
        end
        if (txDone && txError) bothCnt++;
        prevClkDrv = kbdClkDriveLow;
        prevDataDrv = kbdDataDriveLow;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a byte, then keep txValid high with other data to show it is
    // ignored while busy.
    task automatic sendByte(input logic [7:0] data);
        int n;
        n = 0;
        while (!txReady && n < 1000) begin
            tick(1);
            n++;
        end
        txData = data;
        txValid = 1'b1;
        tick(1);
        check("accept_ready_low", txReady, 1'b0);
        txData = 8'h55;
        tick(5);
        txValid = 1'b0;
    endtask

    // Keyboard model: wait for the host request, then clock nFalls falls,
    // sampling data on each rise; pull data low before fall 11 when ack=1.
    task automatic deviceRun(input int nFalls, input logic ack,
                             output logic [9:0] frame, output logic ok);
        int n;
        frame = '0;
        ok = 1'b1;
        n = 0;
        while (!kbdClkDriveLow && n < 20000) begin
            tick(1);
            n++;
        end
        if (!kbdClkDriveLow) ok = 1'b0;
        n = 0;
        while (ok && kbdClkDriveLow && n < INH + 100) begin
            tick(1);
            n++;
        end
        if (kbdClkDriveLow) ok = 1'b0;
        if (ok) begin
            tick(30);
            for (int k = 1; k <= nFalls; k++) begin
                devClkLow = 1'b1;
                tick(HP);
                devClkLow = 1'b0;
                if (k <= 10) frame[k-1] = kbdData;
                if (k == 10) devDataLow = ack;
                tick(HP);
            end
            devDataLow = 1'b0;
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic       parity;
        logic [2:0] ackMask;   // bit i: device acks attempt i
        logic       expDone;
        logic       expErr;
        int         expAtt;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        logic [9:0] frame;
        logic [9:0] expFrame;
        logic       ok;
        int         d0, e0, s0, n, att;
        logic       finished;

        vecs[0] = '{8'hED, 1'b1, 3'b111, 1'b1, 1'b0, 1};
`ifdef PS2_TX_RETRY_EN
        vecs[1] = '{8'hF4, 1'b0, 3'b000, 1'b0, 1'b1, 3};
        vecs[4] = '{8'h80, 1'b0, 3'b010, 1'b1, 1'b0, 2};
`else
        vecs[1] = '{8'hF4, 1'b0, 3'b000, 1'b0, 1'b1, 1};
        vecs[4] = '{8'h80, 1'b0, 3'b010, 1'b0, 1'b1, 1};
`endif
        vecs[2] = '{8'hFF, 1'b1, 3'b111, 1'b1, 1'b0, 1};
        vecs[3] = '{8'h00, 1'b1, 3'b111, 1'b1, 1'b0, 1};
        vecs[5] = '{8'h01, 1'b0, 3'b111, 1'b1, 1'b0, 1};
        vecs[6] = '{8'h5A, 1'b1, 3'b111, 1'b1, 1'b0, 1};

        // reset state
        tick(3);
        check("rst_txReady", txReady, 1'b1);
        check("rst_clkDrive", kbdClkDriveLow, 1'b0);
        check("rst_dataDrive", kbdDataDriveLow, 1'b0);
        check("rst_rxInhibit", rxInhibit, 1'b0);
        check("rst_done_err", {txDone, txError}, 2'b00);
        rst = 1'b0;
        tick(5);

        // table-driven transfers
        for (int i = 0; i < NV; i++) begin
            d0 = doneCnt;
            e0 = errCnt;
            s0 = inhStarts;
            sendByte(vecs[i].data);
            att = 0;
            finished = 1'b0;
            while (att < MAX_ATT && !finished) begin
                exp_q.push_back({1'b1, vecs[i].parity, vecs[i].data});
                deviceRun(11, vecs[i].ackMask[att], frame, ok);
                check($sformatf("v%0d_dev_ok", i), ok, 1'b1);
                expFrame = exp_q.pop_front();
                check($sformatf("v%0d_a%0d_frame", i, att), frame, expFrame);
                check($sformatf("v%0d_inh_len", i), lowLen, INH);
                check($sformatf("v%0d_rts_cycles", i), dataLowInInh, 1);
                check($sformatf("v%0d_rts_data", i), dataLowAtRel, 1'b1);
                check($sformatf("v%0d_rxinh_busy", i), inhAtRel, 1'b1);
                if (vecs[i].ackMask[att]) finished = 1'b1;
                att++;
            end
            n = 0;
            while (doneCnt == d0 && errCnt == e0 && n < 400) begin
                tick(1);
                n++;
            end
            tick(20);
            check($sformatf("v%0d_done", i), doneCnt - d0, vecs[i].expDone);
            check($sformatf("v%0d_err", i), errCnt - e0, vecs[i].expErr);
            check($sformatf("v%0d_attempts", i), inhStarts - s0, vecs[i].expAtt);
            if (vecs[i].expDone) begin
                check($sformatf("v%0d_ready_at_done", i), doneReady, 1'b1);
                check($sformatf("v%0d_rxinh_at_done", i), doneInh, 1'b0);
            end
            check($sformatf("v%0d_idle_ready", i), txReady, 1'b1);
        end

        // timeout: device never clocks
        d0 = doneCnt;
        e0 = errCnt;
        s0 = inhStarts;
        sendByte(8'h00);
        n = 0;
        while (errCnt == e0 && n < MAX_ATT * (INH + TMO + 200)) begin
            tick(1);
            n++;
        end
        check("tmo_err", errCnt - e0, 1);
        check("tmo_latency", errCyc - relCyc, TMO);
        check("tmo_attempts", inhStarts - s0, MAX_ATT);
        check("tmo_ready_at_err", errReady, 1'b1);
        tick(1);
        check("tmo_no_done", doneCnt - d0, 0);
        check("tmo_clk_rel", kbdClkDriveLow, 1'b0);
        check("tmo_data_rel", kbdDataDriveLow, 1'b0);
        check("tmo_ready", txReady, 1'b1);

        // reset while inhibiting
        d0 = doneCnt;
        e0 = errCnt;
        sendByte(8'h00);
        tick(100);
        check("rstinh_pre_clk", kbdClkDriveLow, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rstinh_clk_rel", kbdClkDriveLow, 1'b0);
        check("rstinh_data_rel", kbdDataDriveLow, 1'b0);
        check("rstinh_ready", txReady, 1'b1);
        check("rstinh_rxinh", rxInhibit, 1'b0);

        // reset after fall 5 of 0xFF, then a clean 0xFF
        sendByte(8'hFF);
        deviceRun(5, 1'b1, frame, ok);
        check("rst5_dev_ok", ok, 1'b1);
        check("rst5_busy", rxInhibit, 1'b1);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst5_clk_rel", kbdClkDriveLow, 1'b0);
        check("rst5_data_rel", kbdDataDriveLow, 1'b0);
        check("rst5_ready", txReady, 1'b1);
        tick(50);
        check("rst5_no_pulse", (doneCnt - d0) + (errCnt - e0), 0);
        sendByte(8'hFF);
        exp_q.push_back({1'b1, 1'b1, 8'hFF});
        deviceRun(11, 1'b1, frame, ok);
        expFrame = exp_q.pop_front();
        check("ff2_frame", frame, expFrame);
        n = 0;
        while (doneCnt == d0 && n < 400) begin
            tick(1);
            n++;
        end
        tick(20);
        check("ff2_done", doneCnt - d0, 1);
        check("ff2_no_err", errCnt - e0, 0);

        check("never_both", bothCnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if something stalls beyond every bounded wait.
    initial begin
        #(10 * 160000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
